// File: rtl/audio_codec_cfg_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// audio_cfg_pkg
// Shared definitions for the audio codec boot-time configuration sequencer:
// FSM state encoding, the default I2C write address of the codec, and the
// codec register map with the values written at boot.
// A configuration word is {reg_addr[6:0], data[8:0]}. The sequencer prefixes
// it with the slave address to form the 24-bit I2C transfer.
// ---------------------------------------------------------------------------
package audio_cfg_pkg;

  // Sequencer states, in the order a normal boot walks through them
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_GAP,
    ST_GO,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } cfgState_t;

  // 7-bit address 0x1A shifted left with R/W=0
  localparam logic [7:0] SLAVE_ADDR_DEFAULT = 8'h34;

  // Codec register addresses
  localparam logic [6:0] REG_LINE_IN_L  = 7'h00;
  localparam logic [6:0] REG_LINE_IN_R  = 7'h01;
  localparam logic [6:0] REG_HP_OUT_L   = 7'h02;
  localparam logic [6:0] REG_HP_OUT_R   = 7'h03;
  localparam logic [6:0] REG_ANA_PATH   = 7'h04;
  localparam logic [6:0] REG_DIG_PATH   = 7'h05;
  localparam logic [6:0] REG_PWR_DN     = 7'h06;
  localparam logic [6:0] REG_IFACE      = 7'h07;
  localparam logic [6:0] REG_SAMPLING   = 7'h08;
  localparam logic [6:0] REG_ACTIVE     = 7'h09;
  localparam logic [6:0] REG_RESET      = 7'h0F;

  // Boot values: 0 dB line in, 0 dB headphone, DAC to output with line bypass
  // off, no de-emphasis, everything powered, I2S master 16-bit, 48 kHz normal
  // mode, then activate the digital interface last.
  localparam logic [8:0] VAL_RESET      = 9'h000;
  localparam logic [8:0] VAL_LINE_IN    = 9'h017;
  localparam logic [8:0] VAL_HP_OUT     = 9'h079;
  localparam logic [8:0] VAL_ANA_PATH   = 9'h012;
  localparam logic [8:0] VAL_DIG_PATH   = 9'h000;
  localparam logic [8:0] VAL_PWR_DN     = 9'h000;
  localparam logic [8:0] VAL_IFACE      = 9'h042;
  localparam logic [8:0] VAL_SAMPLING   = 9'h000;
  localparam logic [8:0] VAL_ACTIVE     = 9'h001;

  // Packs a register address and its 9-bit value into one table word
  function automatic logic [15:0] cfgWord(input logic [6:0] regAddr,
                                          input logic [8:0] regData);
    return {regAddr, regData};
  endfunction

endpackage

// File: rtl/audio_codec_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// audio_codec_cfg_sequencer_if
// Go/done handshake between the configuration sequencer and the bit-level
// I2C transfer engine.
//   xfer_go    sequencer -> engine  level request, held until xfer_done
//   xfer_data  sequencer -> engine  24-bit word, stable while xfer_go=1
//   xfer_done  engine -> sequencer  transfer finished, sticky while xfer_go=1
//   xfer_nack  engine -> sequencer  1 when any ACK slot was not acknowledged
// The sequencer uses the master modport, the engine the slave modport.
// ---------------------------------------------------------------------------
interface audio_codec_cfg_sequencer_if;

  logic        xfer_go;
  logic [23:0] xfer_data;
  logic        xfer_done;
  logic        xfer_nack;

  modport master (
    output xfer_go,
    output xfer_data,
    input  xfer_done,
    input  xfer_nack
  );

  modport slave (
    input  xfer_go,
    input  xfer_data,
    output xfer_done,
    output xfer_nack
  );

endinterface

// File: rtl/audio_codec_cfg_rom.sv
// ---------------------------------------------------------------------------
// audio_codec_cfg_rom
// Combinational lookup of the codec boot table. Entry 0 is the codec reset
// write; the ACTIVE write must stay last so the digital interface is only
// enabled once every other register is set up. Out-of-range indices read 0.
// Ports:
//   index_i  in   IDX_W  table index
//   word_o   out  16     {reg_addr[6:0], data[8:0]}
// ---------------------------------------------------------------------------
module audio_codec_cfg_rom
  import audio_cfg_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] index_i,
  output logic [15:0]      word_o
);

  // Table decode; anything past the last entry falls through to zero
  always_comb begin
    word_o = 16'h0000;
    case (int'(index_i))
      0:       word_o = cfgWord(REG_RESET,     VAL_RESET);
      1:       word_o = cfgWord(REG_LINE_IN_L, VAL_LINE_IN);
      2:       word_o = cfgWord(REG_LINE_IN_R, VAL_LINE_IN);
      3:       word_o = cfgWord(REG_HP_OUT_L,  VAL_HP_OUT);
      4:       word_o = cfgWord(REG_HP_OUT_R,  VAL_HP_OUT);
      5:       word_o = cfgWord(REG_ANA_PATH,  VAL_ANA_PATH);
      6:       word_o = cfgWord(REG_DIG_PATH,  VAL_DIG_PATH);
      7:       word_o = cfgWord(REG_PWR_DN,    VAL_PWR_DN);
      8:       word_o = cfgWord(REG_IFACE,     VAL_IFACE);
      9:       word_o = cfgWord(REG_SAMPLING,  VAL_SAMPLING);
      10:      word_o = cfgWord(REG_ACTIVE,    VAL_ACTIVE);
      default: word_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/audio_codec_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// audio_codec_cfg_sequencer
// Boot-time sequencer for the audio codec I2C control port. After a start
// pulse it waits for the codec to power up, then hands each table word to the
// I2C transfer engine, retrying NACKed or hung transfers up to MAX_RETRIES
// times, and finally reports done or error.
// Ports:
//   i2c_clk    in   1      clock, all logic on rising edge
//   reset      in   1      asynchronous, active-low
//   start      in   1      pulse: run/re-run the table from index 0
//   xfer       if   -      master side of the go/done engine handshake
//   busy       out  1      sequence in progress
//   cfg_done   out  1      every word acknowledged
//   cfg_error  out  1      retries exhausted on cfg_index
//   cfg_index  out  IDX_W  current (or failing) table index
// Requires NUM_WORDS >= 2, GAP_CYCLES/PWRUP_CYCLES/TIMEOUT_CYC >= 1,
// MAX_RETRIES in 1..7.
// ---------------------------------------------------------------------------
module audio_codec_cfg_sequencer
  import audio_cfg_pkg::*;
#(
  parameter int         NUM_WORDS    = 11,
  parameter logic [7:0] SLAVE_ADDR   = SLAVE_ADDR_DEFAULT,
  parameter int         MAX_RETRIES  = 3,
  parameter int         PWRUP_CYCLES = 50000,
  parameter int         GAP_CYCLES   = 2000,
  parameter int         TIMEOUT_CYC  = 100000,
  localparam int        IDX_W        = $clog2(NUM_WORDS)
) (
  input  logic                        i2c_clk,
  input  logic                        reset,
  input  logic                        start,
  audio_codec_cfg_sequencer_if.master xfer,
  output logic                        busy,
  output logic                        cfg_done,
  output logic                        cfg_error,
  output logic [IDX_W-1:0]            cfg_index
);

  // One shared cycle counter serves power-up, gap and timeout, so it is
  // sized for the largest of the three.
  localparam int PG_MAX  = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (PG_MAX > TIMEOUT_CYC) ? PG_MAX : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRIES - 1);

  cfgState_t         state_q,    state_d;
  logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
  logic [2:0]        retryCnt_q, retryCnt_d;
  logic [IDX_W-1:0]  index_q,    index_d;
  logic [23:0]       data_q,     data_d;
  logic              go_q,       go_d;
  logic              fail_q,     fail_d;
  logic [15:0]       romWord;

  audio_codec_cfg_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .index_i (index_q),
    .word_o  (romWord)
  );

  // State and datapath registers. The asynchronous reset clears go_q, so a
  // reset in the middle of a transfer drops the request without a clock.
  always_ff @(posedge i2c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cycleCnt_q <= '0;
      retryCnt_q <= '0;
      index_q    <= '0;
      data_q     <= '0;
      go_q       <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      retryCnt_q <= retryCnt_d;
      index_q    <= index_d;
      data_q     <= data_d;
      go_q       <= go_d;
      fail_q     <= fail_d;
    end
  end

  // Next-state logic. go_d is only raised from GO and kept in WAIT_DONE, so
  // the request rises one cycle after the data register is loaded and falls
  // on the cycle the transfer is resolved.
  always_comb begin
    state_d    = state_q;
    cycleCnt_d = cycleCnt_q;
    retryCnt_d = retryCnt_q;
    index_d    = index_q;
    data_d     = data_q;
    go_d       = 1'b0;
    fail_d     = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cycleCnt_d = '0;
          state_d    = ST_PWRUP;
        end
      end

      ST_PWRUP: begin
        if (cycleCnt_q == PWRUP_LAST) begin
          cycleCnt_d = '0;
          state_d    = ST_GAP;
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_ONE;
        end
      end

      // The counter parks at its terminal value; leaving additionally waits
      // for the engine to have dropped a done left over from earlier.
      ST_GAP: begin
        if (cycleCnt_q != GAP_LAST) begin
          cycleCnt_d = cycleCnt_q + CNT_ONE;
        end else if (!xfer.xfer_done) begin
          data_d  = {SLAVE_ADDR, romWord};
          state_d = ST_GO;
        end
      end

      ST_GO: begin
        go_d       = 1'b1;
        cycleCnt_d = '0;
        state_d    = ST_WAIT_DONE;
      end

      // done has priority over the timeout in the same cycle
      ST_WAIT_DONE: begin
        if (xfer.xfer_done) begin
          fail_d  = xfer.xfer_nack;
          state_d = ST_CHECK;
        end else if (cycleCnt_q == TIMEOUT_LAST) begin
          fail_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          go_d       = 1'b1;
          cycleCnt_d = cycleCnt_q + CNT_ONE;
        end
      end

      ST_CHECK: begin
        cycleCnt_d = '0;
        state_d    = ST_GAP;
        if (!fail_q) begin
          retryCnt_d = '0;
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + IDX_ONE;
          end
        end else begin
          retryCnt_d = retryCnt_q + 3'd1;
          if (retryCnt_q == RETRY_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_DONE, ST_ERROR: begin
        if (start) begin
          index_d    = '0;
          retryCnt_d = '0;
          cycleCnt_d = '0;
          fail_d     = 1'b0;
          state_d    = ST_PWRUP;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer.xfer_go   = go_q;
  assign xfer.xfer_data = data_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign cfg_done       = (state_q == ST_DONE);
  assign cfg_error      = (state_q == ST_ERROR);
  assign cfg_index      = index_q;

endmodule

// File: tb/tb_audio_codec_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_codec_cfg_sequencer
// Bench for the codec configuration sequencer with shortened timing. A small
// transfer-engine model answers the go/done handshake with programmable
// latency, NACKs and hangs; a reference model expands each scenario into the
// list of words the sequencer should send, and a monitor pops that list as
// transfers start.
// ---------------------------------------------------------------------------
module tb_audio_codec_cfg_sequencer;

  localparam int NUM_WORDS    = 11;
  localparam int MAX_RETRIES  = 3;
  localparam int PWRUP_CYCLES = 200;
  localparam int GAP_CYCLES   = 40;
  localparam int TIMEOUT_CYC  = 300;
  localparam int END_BUDGET   = 30000;

  typedef struct {
    logic [23:0] word;
    bit          hang;
  } xfer_t;

  logic       i2cClk = 1'b0;
  logic       reset  = 1'b0;
  logic       start  = 1'b0;
  logic       busy;
  logic       cfgDone;
  logic       cfgError;
  logic [3:0] cfgIndex;

  audio_codec_cfg_sequencer_if xif ();

  audio_codec_cfg_sequencer #(
    .NUM_WORDS    (NUM_WORDS),
    .SLAVE_ADDR   (8'h34),
    .MAX_RETRIES  (MAX_RETRIES),
    .PWRUP_CYCLES (PWRUP_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .i2c_clk   (i2cClk),
    .reset     (reset),
    .start     (start),
    .xfer      (xif),
    .busy      (busy),
    .cfg_done  (cfgDone),
    .cfg_error (cfgError),
    .cfg_index (cfgIndex)
  );

  always #5 i2cClk = ~i2cClk;

  // Codec boot table as {reg[6:0], data[8:0]}, written out by hand
  logic [15:0] romModel [NUM_WORDS] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201
  };

  int    checks = 0;
  int    passes = 0;
  xfer_t expQ[$];
  bit    expDone;
  bit    expErr;
  int    expIdx;

  // Engine model configuration
  int engDelay    = 120;
  int nackIdx     = -1;
  int nackTimes   = 0;
  int hangIdx     = -1;
  bit engHoldDone = 1'b0;
  int attempts [16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int wordToIndex(input logic [23:0] w);
    for (int i = 0; i < NUM_WORDS; i++)
      if (w === {8'h34, romModel[i]}) return i;
    return -1;
  endfunction

  // Transfer engine: raises done engDelay cycles after go, NACKs the first
  // nackTimes attempts on nackIdx, never answers on hangIdx, and clears done
  // when go drops unless told to leave it stuck.
  int engCnt = 0;
  int engIdx = -1;
  bit engActive = 1'b0;
  always @(negedge i2cClk) begin
    if (!xif.xfer_go) begin
      engActive = 1'b0;
      if (!engHoldDone) begin
        xif.xfer_done = 1'b0;
        xif.xfer_nack = 1'b0;
      end
    end else begin
      if (!engActive) begin
        engActive = 1'b1;
        engCnt    = 0;
        engIdx    = wordToIndex(xif.xfer_data);
        if (engIdx >= 0) attempts[engIdx]++;
      end
      engCnt++;
      if (!xif.xfer_done && engCnt >= engDelay && engIdx != hangIdx) begin
        xif.xfer_done = 1'b1;
        xif.xfer_nack = (engIdx == nackIdx) && (attempts[engIdx] <= nackTimes);
      end
    end
  end

  // Monitor: every rising go must match the next expected word and follow at
  // least GAP_CYCLES idle cycles; hung transfers must time out after exactly
  // TIMEOUT_CYC cycles of go.
  int monLow   = 0;
  int monHigh  = 0;
  bit monPrev  = 1'b0;
  bit monHang  = 1'b0;
  always @(negedge i2cClk) begin
    xfer_t cur;
    #1;
    if (xif.xfer_go && !monPrev) begin
      checks++;
      if (monLow >= GAP_CYCLES) passes++;
      else $display("[TB] FAIL gap: got %0d idle cycles, expected at least %0d", monLow, GAP_CYCLES);
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_xfer: got word 0x%0h, expected no transfer", xif.xfer_data);
        monHang = 1'b0;
      end else begin
        cur = expQ.pop_front();
        checkOutput("xfer_word", {8'h0, xif.xfer_data}, {8'h0, cur.word});
        monHang = cur.hang;
      end
      monHigh = 0;
    end
    if (xif.xfer_go) monHigh++;
    if (!xif.xfer_go && monPrev && monHang)
      checkOutput("timeout_len", monHigh, TIMEOUT_CYC);
    monLow  = xif.xfer_go ? 0 : monLow + 1;
    monPrev = xif.xfer_go;
  end

  // Reference model: per word, attempts continue until one succeeds or the
  // retry budget runs out, then the run ends in DONE or ERROR.
  task automatic buildExpected(input int nIdx, input int nTimes, input int hIdx);
    expDone = 1'b1;
    expErr  = 1'b0;
    expIdx  = NUM_WORDS - 1;
    for (int i = 0; i < NUM_WORDS; i++) begin
      bit ok;
      ok = 1'b0;
      for (int a = 1; a <= MAX_RETRIES; a++) begin
        xfer_t e;
        e.word = {8'h34, romModel[i]};
        e.hang = (i == hIdx);
        expQ.push_back(e);
        if (!((i == hIdx) || (i == nIdx && a <= nTimes))) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        expDone = 1'b0;
        expErr  = 1'b1;
        expIdx  = i;
        return;
      end
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge i2cClk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int delay, input int nIdx, input int nTimes,
                               input int hIdx);
    engDelay  = delay;
    nackIdx   = nIdx;
    nackTimes = nTimes;
    hangIdx   = hIdx;
    for (int i = 0; i < 16; i++) attempts[i] = 0;
    buildExpected(nIdx, nTimes, hIdx);
    pulseStart();
  endtask

  task automatic finishRun(input string tag);
    int n;
    n = 0;
    while (!(cfgDone || cfgError) && n < END_BUDGET) begin
      @(negedge i2cClk);
      #1;
      n++;
    end
    if (n >= END_BUDGET) begin
      checks++;
      $display("[TB] FAIL %s_end_timeout: got no done/error in %0d cycles, expected one", tag, n);
    end
    checkOutput({tag, "_cfg_done"},  cfgDone,  expDone);
    checkOutput({tag, "_cfg_error"}, cfgError, expErr);
    checkOutput({tag, "_cfg_index"}, cfgIndex, expIdx);
    checkOutput({tag, "_busy"},      busy,     0);
    checkOutput({tag, "_xfer_go"},   xif.xfer_go, 0);
    checkOutput({tag, "_pending"},   expQ.size(), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  lat;
    int  n;
    bit  goSeen;
    xif.xfer_done = 1'b0;
    xif.xfer_nack = 1'b0;

    $display("[TB] reset values");
    repeat (3) @(negedge i2cClk);
    #1;
    checkOutput("rst_xfer_go",   xif.xfer_go,   0);
    checkOutput("rst_xfer_data", xif.xfer_data, 0);
    checkOutput("rst_busy",      busy,          0);
    checkOutput("rst_cfg_done",  cfgDone,       0);
    checkOutput("rst_cfg_error", cfgError,      0);
    checkOutput("rst_cfg_index", cfgIndex,      0);
    reset = 1'b1;
    @(negedge i2cClk);
    #1;

    $display("[TB] test 1: all words acknowledged");
    applyStimulus(120, -1, 0, -1);
    checkOutput("t1_busy", busy, 1);
    lat = 1;
    while (!xif.xfer_go && lat < PWRUP_CYCLES + GAP_CYCLES + 50) begin
      @(negedge i2cClk);
      #1;
      lat++;
    end
    checkOutput("t1_first_go_latency", lat, PWRUP_CYCLES + GAP_CYCLES + 2);
    finishRun("t1");

    $display("[TB] test 2: two NACKs on index 3");
    applyStimulus($urandom_range(10, 150), 3, 2, -1);
    finishRun("t2");
    checkOutput("t2_attempts_idx3", attempts[3], 3);

    $display("[TB] test 3: index 5 always NACKed");
    applyStimulus($urandom_range(10, 150), 5, 99, -1);
    finishRun("t3");
    checkOutput("t3_attempts_idx5", attempts[5], 3);
    checkOutput("t3_attempts_idx6", attempts[6], 0);

    $display("[TB] test 4: engine hangs on index 0");
    applyStimulus(50, -1, 0, 0);
    finishRun("t4");
    checkOutput("t4_attempts_idx0", attempts[0], 3);

    $display("[TB] test 5: start while busy, then restart from DONE");
    applyStimulus(60, -1, 0, -1);
    n = 0;
    while (!(xif.xfer_go && cfgIndex == 4'd2) && n < END_BUDGET) begin
      @(negedge i2cClk);
      #1;
      n++;
    end
    checkOutput("t5_reached_idx2", xif.xfer_go && cfgIndex == 4'd2, 1);
    pulseStart();
    checkOutput("t5_busy_after_start", busy, 1);
    checkOutput("t5_index_after_start", cfgIndex, 2);
    finishRun("t5a");
    applyStimulus($urandom_range(10, 150), -1, 0, -1);
    finishRun("t5b");

    $display("[TB] test 6: reset during transfer with done stuck high");
    applyStimulus(30, -1, 0, -1);
    engHoldDone = 1'b1;
    n = 0;
    while (!(xif.xfer_go && xif.xfer_done) && n < END_BUDGET) begin
      @(negedge i2cClk);
      #1;
      n++;
    end
    checkOutput("t6_reached_wait", xif.xfer_go && xif.xfer_done, 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_xfer_go",   xif.xfer_go,   0);
    checkOutput("t6_rst_xfer_data", xif.xfer_data, 0);
    checkOutput("t6_rst_busy",      busy,          0);
    checkOutput("t6_rst_cfg_done",  cfgDone,       0);
    checkOutput("t6_rst_cfg_error", cfgError,      0);
    checkOutput("t6_rst_cfg_index", cfgIndex,      0);
    expQ.delete();
    repeat (2) @(negedge i2cClk);
    #1;
    reset = 1'b1;
    applyStimulus(30, -1, 0, -1);
    goSeen = 1'b0;
    repeat (PWRUP_CYCLES + GAP_CYCLES + 20) begin
      @(negedge i2cClk);
      #1;
      if (xif.xfer_go) goSeen = 1'b1;
    end
    checkOutput("t6_go_blocked", goSeen, 0);
    engHoldDone = 1'b0;
    @(negedge i2cClk);
    #1;
    lat = 0;
    while (!xif.xfer_go && lat < 20) begin
      @(negedge i2cClk);
      #1;
      lat++;
    end
    checkOutput("t6_go_after_done_clear", lat, 2);
    finishRun("t6");

    $display("[TB] randomized runs");
    for (int r = 0; r < 4; r++) begin
      int h;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_WORDS - 1)) : -1;
      applyStimulus($urandom_range(5, 150), $urandom_range(0, NUM_WORDS - 1),
                    $urandom_range(0, 3), h);
      finishRun("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
